link_unpack_ctrl: RTL and testbench
===================================

Name: link_unpack_ctrl

Overview:
Sequencing controller for the 21-bit to 10-bit link unpacking datapath. It takes 21-bit link words from an upstream valid/ready source and emits a stream of 10-bit symbols, LSB-first, to a downstream valid/ready sink. It tracks word phase (0..9) and symbol position (0..20) within the 210-bit frame, and handles backpressure, enable/drain and flush resynchronisation. It sits between the link receiver and the symbol decoder and replaces free-running phase counting with flow-controlled sequencing.

Parameters:
IN_W, 21, input word width; must be SYM_W*2+1 for frame math below
SYM_W, 10, output symbol width
FRAME_WORDS, 10, words per frame; frame = IN_W*FRAME_WORDS bits = 21 symbols
ACC_W, 30, accumulator width = IN_W+SYM_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  run enable; deassert = drain then idle
flush  in  1  synchronous resync pulse; drops all buffered bits
in_data  in  21  link word, bit 0 first on the wire
in_valid  in  1  upstream word valid
in_ready  out  1  word accepted when in_valid&in_ready
sym_data  out  10  current symbol = acc[9:0]
sym_valid  out  1  symbol available (fill>=10)
sym_ready  in  1  downstream accepts when sym_valid&sym_ready
sym_last  out  1  sym_valid and symbol is 21st of frame
phase  out  4  index of next word to accept, 0..9
sym_count  out  5  index of current symbol in frame, 0..20
busy  out  1  state != IDLE or fill != 0

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=0, fill=0, phase=0, sym_count=0; in_ready=0, sym_valid=0, sym_last=0, busy=0.
- States: IDLE -> RUN when en=1. RUN -> DRAIN when en=0. DRAIN -> IDLE when fill<10. IDLE/DRAIN -> RUN when en=1 and fill<10.
- On entering IDLE: residual bits (fill<10) are discarded. fill, phase and sym_count reset to 0.
- emit = sym_valid & sym_ready. sym_valid = (fill>=10), driven from registers only.
- in_ready asserts only in RUN and is combinational: (fill<=9) | (fill<=19 & emit). It may depend on sym_ready; no other path depends on in_ready.
- Accept with emit in the same cycle: acc = (acc>>10) | (in_data << (fill-10)); fill += 11.
- Accept without emit: acc |= in_data << fill; fill += 21.
- Emit without accept: acc >>= 10; fill -= 10.
- fill never exceeds 30; a bench assertion must check this.
- Latency: a word accepted at cycle N with fill=0 gives sym_valid=1 at N+1.
- While sym_valid=1 and sym_ready=0, sym_data and sym_last hold stable.
- phase increments per accepted word and wraps 9->0.
- sym_count increments per emit and wraps 20->0. sym_last = sym_valid & (sym_count==20).
- At a frame boundary (phase wraps and all 21 symbols emitted) fill is exactly 0. A bench assertion must check this.
- flush=1, highest priority after reset: next cycle acc=0, fill=0, phase=0, sym_count=0, sym_valid=0. State becomes RUN if en=1, else IDLE. in_ready is forced 0 during the flush cycle, so any word offered then is not accepted.
- en falling mid-frame: stop accepting immediately and emit all complete symbols. Phase/sym_count are not preserved across IDLE.

Decomposition:
- Package link_pkg: IN_W, SYM_W, FRAME_WORDS, ACC_W, state enum (IDLE, RUN, DRAIN), width typedefs for phase and sym_count.
- One sub-module, link_bit_accum: acc/fill register, shift/merge datapath, accept/emit inputs.
- The FSM, handshakes and counters stay in link_unpack_ctrl.

Test Plan:
- Basic unpack: en=1, sym_ready=1, word0=21'h100C01. Expect symbols 10'h001, 10'h003. Then with word1=21'h0, expect next symbol 10'h001 (leftover bit 20 = 1).
- Full frame: 10 words of 21'h1FFFFF with continuous ready. Expect 21 symbols 10'h3FF, sym_last only on the 21st, phase=0, sym_count=0, fill=0 after.
- Backpressure: accept one word (fill=21), hold sym_ready=0 for 5 cycles. Expect in_ready=0, sym_valid=1, sym_data stable. On release, expect 2 symbols and in_ready=1 once fill<=19 with emit.
- Drain: drop en after word 3 (63 bits). Expect exactly 6 symbols, 3 bits discarded, state=IDLE, busy=0, phase=0.
- Flush mid-frame at phase=5 with words pending. Expect sym_valid=0 next cycle and counters 0. The next word realigns: word 21'h00155 gives symbol 10'h155 first.
- Async reset mid-frame: rst=0 between clock edges. Expect all outputs 0 immediately, and no symbol emitted on the following edge.

Source files
------------

// File: rtl/link_pkg.sv
// Shared widths, frame geometry and FSM encoding for the 21-bit to 10-bit link unpacker.
package link_pkg;
    localparam int IN_W        = 21;
    localparam int SYM_W       = 10;
    localparam int FRAME_WORDS = 10;
    localparam int ACC_W       = IN_W + SYM_W - 1;
    localparam int FRAME_SYMS  = (IN_W * FRAME_WORDS) / SYM_W;
    localparam int FILL_W      = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [3:0]        phase_t;
    typedef logic [4:0]        sym_count_t;
    typedef logic [FILL_W-1:0] fill_t;
endpackage

// File: rtl/link_bit_accum.sv
// Bit accumulator: merges accepted words above the valid bits and shifts out 10-bit symbols LSB-first.
module link_bit_accum
    import link_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic             emit,
    input  logic [IN_W-1:0]  in_data,
    output logic [SYM_W-1:0] sym_data,
    output fill_t            fill
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] word_ext;
    fill_t            fill_next;

    assign word_ext = ACC_W'(in_data);
    assign sym_data = acc[SYM_W-1:0];

    // Bits above fill are always zero, so merging by OR is safe.
    always_comb begin
        acc_next  = acc;
        fill_next = fill;
        if (clear) begin
            acc_next  = '0;
            fill_next = '0;
        end else if (accept && emit) begin
            acc_next  = (acc >> SYM_W) | (word_ext << (fill - fill_t'(SYM_W)));
            fill_next = fill + fill_t'(IN_W - SYM_W);
        end else if (accept) begin
            acc_next  = acc | (word_ext << fill);
            fill_next = fill + fill_t'(IN_W);
        end else if (emit) begin
            acc_next  = acc >> SYM_W;
            fill_next = fill - fill_t'(SYM_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            fill <= '0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;
        end
    end
endmodule

// File: rtl/link_unpack_ctrl.sv
// Flow-controlled sequencer: word/symbol handshakes, frame counters, enable/drain and flush.
module link_unpack_ctrl
    import link_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SYM_W-1:0] sym_data,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             sym_last,
    output phase_t           phase,
    output sym_count_t       sym_count,
    output logic             busy
);
    // Both ports: a transfer happens on a rising edge where valid & ready are high;
    // sym_valid is register-driven, in_ready may follow sym_ready combinationally.
    state_t state;
    state_t state_next;
    fill_t  fill;
    logic   accept;
    logic   emit;
    logic   clear;

    assign sym_valid = (fill >= fill_t'(SYM_W));
    assign emit      = sym_valid & sym_ready;
    assign accept    = in_valid & in_ready;

    link_bit_accum u_accum (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .accept   (accept),
        .emit     (emit),
        .in_data  (in_data),
        .sym_data (sym_data),
        .fill     (fill)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = en ? RUN : IDLE;
        end else begin
            case (state)
                IDLE:    if (en) state_next = RUN;
                RUN:     if (!en) state_next = DRAIN;
                DRAIN:   if (fill < fill_t'(SYM_W)) state_next = en ? RUN : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Entering IDLE throws away the sub-symbol residue and restarts frame alignment.
    always_comb begin
        in_ready = 1'b0;
        if (state == RUN && en && !flush)
            in_ready = (fill <= fill_t'(SYM_W - 1)) |
                       ((fill <= fill_t'(2 * SYM_W - 1)) & emit);
        clear    = flush | ((state_next == IDLE) && (state != IDLE));
        sym_last = sym_valid & (sym_count == sym_count_t'(FRAME_SYMS - 1));
        busy     = (state != IDLE) | (fill != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= '0;
            sym_count <= '0;
        end else if (clear) begin
            phase     <= '0;
            sym_count <= '0;
        end else begin
            if (accept)
                phase <= (phase == phase_t'(FRAME_WORDS - 1)) ? '0 : phase + phase_t'(1);
            if (emit)
                sym_count <= (sym_count == sym_count_t'(FRAME_SYMS - 1)) ? '0
                                                                        : sym_count + sym_count_t'(1);
        end
    end
endmodule

// File: tb/tb_link_unpack_ctrl.sv
// Directed bench for link_unpack_ctrl with a bit-level unpacking model feeding a symbol scoreboard.
module tb_link_unpack_ctrl;
    import link_pkg::*;

    logic             clk;
    logic             rst;
    logic             en;
    logic             flush;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] sym_data;
    logic             sym_valid;
    logic             sym_ready;
    logic             sym_last;
    phase_t           phase;
    sym_count_t       sym_count;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_emit   = 0;
    int n_last   = 0;
    logic rand_ready = 1'b0;

    // Model: {last, symbol} entries produced as soon as enough bits are accepted.
    logic [SYM_W:0] exp_q[$];
    logic [63:0]    mbits;
    int             mfill;
    int             msym;

    link_unpack_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_last  (sym_last),
        .phase     (phase),
        .sym_count (sym_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        mbits = '0;
        mfill = 0;
        msym  = 0;
    endtask

    task automatic model_push(input logic [IN_W-1:0] w);
        mbits = mbits | (64'(w) << mfill);
        mfill += IN_W;
        while (mfill >= SYM_W) begin
            exp_q.push_back({(msym == FRAME_SYMS - 1), mbits[SYM_W-1:0]});
            mbits = mbits >> SYM_W;
            mfill -= SYM_W;
            msym = (msym == FRAME_SYMS - 1) ? 0 : msym + 1;
        end
    endtask

    // Transfers are decided by values stable at the falling edge and take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst || flush) begin
            model_clear();
        end else begin
            check("fill_max", 32'(dut.fill <= 5'd30), 32'd1);
            if (sym_valid && sym_ready) begin
                n_emit++;
                check("emit_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [SYM_W:0] e;
                    e = exp_q.pop_front();
                    check("sym", 32'({sym_last, sym_data}), 32'(e));
                end
                if (sym_last) begin
                    n_last++;
                    check("frame_phase", 32'(phase), 32'd0);
                    check("frame_fill", 32'(dut.fill), 32'd10);
                end
            end
            if (in_valid && in_ready) model_push(in_data);
        end
    end

    task automatic send_word(input logic [IN_W-1:0] w);
        int k = 0;
        in_data  = w;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready || k >= 50) break;
            k++;
            @(posedge clk); #1;
            if (rand_ready) sym_ready = 1'($urandom_range(0, 1));
        end
        check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_ready) sym_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_word(IN_W'($urandom_range(0, 32'h1FFFFF)));
    endtask

    task automatic wait_drained(input int budget);
        int k = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || sym_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 32'(k < budget), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0] w0;
        logic [IN_W-1:0] w1;
        int base;
        int k;

        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; sym_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_sym_last", 32'(sym_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_sym_count", 32'(sym_count), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Basic unpack, then pad out the frame with zero words.
        en = 1'b1; sym_ready = 1'b1;
        send_word(21'h100C01);
        check("basic_latency_valid", 32'(sym_valid), 32'd1);
        check("basic_sym0", 32'(sym_data), 32'h001);
        send_word(21'h000000);
        check("basic_sym2", 32'(sym_data), 32'h001);
        for (int i = 0; i < 8; i++) send_word(21'h000000);
        wait_drained(100);
        check("basic_phase", 32'(phase), 32'd0);
        check("basic_sym_count", 32'(sym_count), 32'd0);
        check("basic_fill", 32'(dut.fill), 32'd0);

        // Full frame of ones with continuous ready.
        base = n_emit; k = n_last;
        for (int i = 0; i < FRAME_WORDS; i++) send_word(21'h1FFFFF);
        wait_drained(100);
        check("full_emits", 32'(n_emit - base), 32'd21);
        check("full_lasts", 32'(n_last - k), 32'd1);
        check("full_phase", 32'(phase), 32'd0);
        check("full_sym_count", 32'(sym_count), 32'd0);
        check("full_fill", 32'(dut.fill), 32'd0);

        // Backpressure: one word buffered, ready withheld for 5 cycles.
        sym_ready = 1'b0;
        w0 = 21'h0ABCDE;
        w1 = 21'h13579B;
        send_word(w0);
        in_data = w1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sym_valid", 32'(sym_valid), 32'd1);
            check("bp_sym_data", 32'(sym_data), 32'(w0[SYM_W-1:0]));
            @(posedge clk); #1;
        end
        sym_ready = 1'b1;
        base = n_emit;
        send_word(w1);
        check("bp_emits_before_accept", 32'(n_emit - base), 32'd2);
        rand_ready = 1'b1;
        send_random(8);
        rand_ready = 1'b0; sym_ready = 1'b1;
        wait_drained(200);
        check("bp_fill", 32'(dut.fill), 32'd0);

        // Drain: en drops after three words (63 bits).
        base = n_emit;
        send_random(3);
        en = 1'b0;
        in_data = 21'h0F0F0F; in_valid = 1'b1;
        @(negedge clk);
        check("drain_no_accept", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_timeout", 32'(k < 100), 32'd1);
        check("drain_emits", 32'(n_emit - base), 32'd6);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_phase", 32'(phase), 32'd0);
        check("drain_sym_count", 32'(sym_count), 32'd0);
        check("drain_state", 32'(dut.state), 32'(IDLE));
        model_clear();

        // Flush mid-frame at phase 5 with symbols pending.
        en = 1'b1;
        send_random(5);
        check("flush_pre_phase", 32'(phase), 32'd5);
        sym_ready = 1'b0;
        @(negedge clk);
        check("flush_pre_valid", 32'(sym_valid), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1; in_data = 21'h1AAAAA; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_sym_valid", 32'(sym_valid), 32'd0);
        check("flush_phase", 32'(phase), 32'd0);
        check("flush_sym_count", 32'(sym_count), 32'd0);
        check("flush_fill", 32'(dut.fill), 32'd0);
        @(posedge clk); #1;
        sym_ready = 1'b1;
        send_word(21'h000155);
        check("flush_realign_valid", 32'(sym_valid), 32'd1);
        check("flush_realign_sym", 32'(sym_data), 32'h155);
        rand_ready = 1'b1;
        send_random(9);
        rand_ready = 1'b0; sym_ready = 1'b1;
        wait_drained(200);
        check("flush_frame_fill", 32'(dut.fill), 32'd0);
        check("flush_frame_phase", 32'(phase), 32'd0);

        // Asynchronous reset between edges, mid-frame.
        send_random(3);
        sym_ready = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_sym_valid", 32'(sym_valid), 32'd0);
        check("arst_sym_last", 32'(sym_last), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_phase", 32'(phase), 32'd0);
        check("arst_sym_count", 32'(sym_count), 32'd0);
        check("arst_sym_data", 32'(sym_data), 32'd0);
        sym_ready = 1'b1;
        base = n_emit;
        @(posedge clk); #1;
        check("arst_no_emit", 32'(n_emit - base), 32'd0);
        check("arst_hold_valid", 32'(sym_valid), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        base = n_emit;
        rand_ready = 1'b1;
        send_random(FRAME_WORDS);
        rand_ready = 1'b0; sym_ready = 1'b1;
        wait_drained(200);
        check("arst_frame_emits", 32'(n_emit - base), 32'd21);
        check("arst_frame_fill", 32'(dut.fill), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
